// File: rtl/ram_4x16_if.sv
// ram_4x16_if: RAM4 data/address/strobe bundle; parity ports exist only with RAM4_PARITY_EN
interface ram_4x16_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic [1:0] addr_in;
  logic load_in;
  logic clear_in;
  logic busy_out;
`ifdef RAM4_PARITY_EN
  logic parity_inject_in;
  logic parity_err_out;
  modport master(output data_in, addr_in, load_in, clear_in, parity_inject_in, input data_out, busy_out, parity_err_out);
  modport slave(input data_in, addr_in, load_in, clear_in, parity_inject_in, output data_out, busy_out, parity_err_out);
`else
  modport master(output data_in, addr_in, load_in, clear_in, input data_out, busy_out);
  modport slave(input data_in, addr_in, load_in, clear_in, output data_out, busy_out);
`endif
endinterface

// File: rtl/ram_4x16.sv
// ram_4x16: four-word register memory with sequenced clear-all and live reads.
// Optional per-word parity storage and check when RAM4_PARITY_EN is defined.
module demux_1x4 (
  input  logic       in_in,
  input  logic [1:0] sel_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic       d_out
);
  assign a_out = in_in && sel_in == 2'd0;
  assign b_out = in_in && sel_in == 2'd1;
  assign c_out = in_in && sel_in == 2'd2;
  assign d_out = in_in && sel_in == 2'd3;
endmodule

module ram_4x16 #(parameter int WIDTH = 16) (
  input logic clk_in,
  input logic rst_in,
  ram_4x16_if.slave bus
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t r_state, w_next;
  logic [1:0] r_clr_cnt;
  logic [WIDTH-1:0] r_word [4];
  logic [3:0] w_load;
  logic w_we;
  // a clear request wins over a same-cycle load, and CLEAR ignores loads entirely
  assign w_we = bus.load_in && !bus.clear_in && r_state == IDLE;
  demux_1x4 u_demux (
    .in_in(w_we),
    .sel_in(bus.addr_in),
    .a_out(w_load[0]),
    .b_out(w_load[1]),
    .c_out(w_load[2]),
    .d_out(w_load[3])
  );
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = bus.clear_in ? CLEAR : IDLE;
    else w_next = r_clr_cnt == 2'd3 ? IDLE : CLEAR;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_clr_cnt <= 2'd0;
      for (int k = 0; k < 4; k++) r_word[k] <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == CLEAR) begin
        r_word[r_clr_cnt] <= '0;
        r_clr_cnt <= r_clr_cnt + 2'd1;
      end
      for (int k = 0; k < 4; k++) if (w_load[k]) r_word[k] <= bus.data_in;
    end
  end
  assign bus.data_out = r_word[bus.addr_in];
  assign bus.busy_out = r_state == CLEAR;
`ifdef RAM4_PARITY_EN
  logic [3:0] r_par;
  always_ff @(posedge clk_in) begin
    if (rst_in) r_par <= '0;
    else begin
      if (r_state == CLEAR) r_par[r_clr_cnt] <= 1'b0;
      for (int k = 0; k < 4; k++) if (w_load[k]) r_par[k] <= ^bus.data_in ^ bus.parity_inject_in;
    end
  end
  assign bus.parity_err_out = ^{r_word[bus.addr_in], r_par[bus.addr_in]};
`endif
endmodule

// File: tb/tb_ram_4x16.sv
// tb_ram_4x16: directed test-plan sequences plus random traffic against a cycle-level reference model.
module tb_ram_4x16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  bit armed = 1'b0;
  logic [15:0] m_word [4];
  logic [3:0] m_par;
  int busy_left;
  ram_4x16_if #(.WIDTH(16)) bus ();
  ram_4x16 #(.WIDTH(16)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
  endtask

  task automatic check_outputs(input string phase);
    chk({phase, "_data"}, 32'(bus.data_out), 32'(m_word[bus.addr_in]));
    chk({phase, "_busy"}, 32'(bus.busy_out), 32'(busy_left > 0));
`ifdef RAM4_PARITY_EN
    chk({phase, "_perr"}, 32'(bus.parity_err_out), 32'(^{m_word[bus.addr_in], m_par[bus.addr_in]}));
`endif
  endtask

  task automatic cycle(input logic r, input logic [15:0] d, input logic [1:0] a, input logic ld, input logic clr, input logic inj);
    rst = r;
    bus.data_in = d;
    bus.addr_in = a;
    bus.load_in = ld;
    bus.clear_in = clr;
`ifdef RAM4_PARITY_EN
    bus.parity_inject_in = inj;
`endif
    #1;
    if (armed) check_outputs("pre");
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 4; k++) m_word[k] = '0;
      m_par = '0;
      busy_left = 0;
    end else if (busy_left > 0) begin
      m_word[4 - busy_left] = '0;
      m_par[4 - busy_left] = 1'b0;
      busy_left--;
    end else if (clr) busy_left = 4;
    else if (ld) begin
      m_word[a] = d;
      m_par[a] = ^d ^ inj;
    end
    #1;
    if (r) armed = 1'b1;
    if (armed) check_outputs("post");
  endtask

  task automatic idle_read(input logic [1:0] a);
    cycle(1'b0, 16'h0, a, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] fill [4];
    logic [1:0] order [4];
    fill = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    order = '{2'd3, 2'd0, 2'd2, 2'd1};
    for (int k = 0; k < 4; k++) m_word[k] = '0;
    m_par = '0;
    busy_left = 0;
    @(negedge clk);
    cycle(1'b1, 16'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) idle_read(2'(k));
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, fill[k], 2'(k), 1'b1, 1'b0, 1'b0);
      for (int j = 0; j < 4; j++) idle_read(2'(j));
    end
    for (int k = 0; k < 4; k++) idle_read(order[k]);
    cycle(1'b0, 16'hBEEF, 2'd2, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) idle_read(2'(k));
    for (int k = 0; k < 4; k++) idle_read(2'(k));
    for (int k = 0; k < 4; k++) cycle(1'b0, 16'hFFFF, 2'(k), 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 2'd3, 1'b0, 1'b1, 1'b0);
    idle_read(2'd3);
    idle_read(2'd3);
    cycle(1'b1, 16'h0, 2'd3, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) idle_read(2'(k));
    for (int k = 0; k < 4; k++) cycle(1'b0, 16'hFFFF, 2'(k), 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 2'd3, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 16'h5A5A, 2'd3, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 16'h5A5A, 2'd3, 1'b1, 1'b1, 1'b0);
    idle_read(2'd3);
    idle_read(2'd3);
    idle_read(2'd3);
    for (int k = 0; k < 10; k++) cycle(1'b0, 16'h0, 2'(k), 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0007, 2'd0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 16'h0007, 2'd1, 1'b1, 1'b0, 1'b1);
    idle_read(2'd1);
    idle_read(2'd0);
    cycle(1'b0, 16'h0, 2'd1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) idle_read(2'(k));
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 49) == 0, 16'($urandom), 2'($urandom), 1'($urandom),
            $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
